// File: rtl/cdb_arbiter.sv
// cdb_arbiter: rotating-priority arbiter packing up to CDB_W FU completions per cycle onto a registered CDB.
// Define CDB_ARB_PERF_EN to add the perf_grants / perf_stall_cycles counters.

module cdb_arbiter_slot #(
    parameter int NUM_FU = 6,
    parameter int W      = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_FU-1:0]          sel,
    input  logic [NUM_FU-1:0][W-1:0]   data,
    output logic                       valid,
    output logic [W-1:0]               q
);
    logic [W-1:0] mux;

    // sel is one-hot or zero, so an AND-OR mux yields all-zero payload for an empty slot
    always_comb begin
        mux = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (sel[i]) mux = mux | data[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            valid <= |sel;
            q     <= mux;
        end
    end
endmodule

module cdb_arbiter #(
    parameter int NUM_FU = 6,
    parameter int CDB_W  = 3,
    parameter int TAG_W  = 5,
    parameter int XLEN   = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic [NUM_FU-1:0]         fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
    input  logic [NUM_FU*XLEN-1:0]    fu_value,
    input  logic [NUM_FU-1:0]         fu_take_branch,
    input  logic [NUM_FU*XLEN-1:0]    fu_npc,
    input  logic [NUM_FU-1:0]         fu_halt,
    output logic [NUM_FU-1:0]         fu_ready,
    output logic [CDB_W-1:0]          cdb_valid,
    output logic [CDB_W*TAG_W-1:0]    cdb_tag,
    output logic [CDB_W*XLEN-1:0]     cdb_value,
    output logic [CDB_W-1:0]          cdb_take_branch,
    output logic [CDB_W*XLEN-1:0]     cdb_npc,
    output logic [CDB_W-1:0]          cdb_halt
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]               perf_grants,
    output logic [31:0]               perf_stall_cycles
`endif
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        logic             take_branch;
        logic [XLEN-1:0]  npc;
        logic             halt;
    } cdb_pay_t;

    localparam int PAY_W = $bits(cdb_pay_t);

    logic [PTR_W-1:0]                  rr_ptr;
    logic [PTR_W-1:0]                  rr_nxt;
    logic [NUM_FU-1:0]                 ready_c;
    logic [CDB_W-1:0][NUM_FU-1:0]      slot_sel;
    logic [NUM_FU-1:0][PAY_W-1:0]      fu_pay;
    logic [CDB_W-1:0][PAY_W-1:0]       slot_q;
    logic [CDB_W-1:0]                  slot_v;
    logic                              grant_en;
    logic                              any_grant;
    int                                grant_cnt;
    int                                last_idx;
    int                                idx;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign fu_pay[i] = {fu_tag[i*TAG_W +: TAG_W], fu_value[i*XLEN +: XLEN],
                            fu_take_branch[i], fu_npc[i*XLEN +: XLEN], fu_halt[i]};
    end

    assign grant_en = !reset && !squash;

    // Rotating scan from rr_ptr; the k-th hit lands in slot k so slots stay gap-free
    always_comb begin
        ready_c   = '0;
        slot_sel  = '0;
        grant_cnt = 0;
        last_idx  = 0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (grant_en && fu_valid[idx] && grant_cnt < CDB_W) begin
                ready_c[idx]             = 1'b1;
                slot_sel[grant_cnt][idx] = 1'b1;
                grant_cnt                = grant_cnt + 1;
                last_idx                 = idx;
                any_grant                = 1'b1;
            end
        end
    end

    always_comb begin
        rr_nxt = rr_ptr;
        if (any_grant) begin
            rr_nxt = (last_idx == NUM_FU - 1) ? '0 : PTR_W'(last_idx + 1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) rr_ptr <= '0;
        else       rr_ptr <= rr_nxt;
    end

    assign fu_ready = ready_c;

    for (genvar k = 0; k < CDB_W; k++) begin : g_slot
        cdb_pay_t s;

        cdb_arbiter_slot #(.NUM_FU(NUM_FU), .W(PAY_W)) u_slot (
            .clock (clock),
            .reset (reset),
            .sel   (slot_sel[k]),
            .data  (fu_pay),
            .valid (slot_v[k]),
            .q     (slot_q[k])
        );

        assign s                                = slot_q[k];
        assign cdb_valid[k]                     = slot_v[k];
        assign cdb_tag[k*TAG_W +: TAG_W]        = s.tag;
        assign cdb_value[k*XLEN +: XLEN]        = s.value;
        assign cdb_take_branch[k]               = s.take_branch;
        assign cdb_npc[k*XLEN +: XLEN]          = s.npc;
        assign cdb_halt[k]                      = s.halt;
    end

`ifdef CDB_ARB_PERF_EN
    logic [32:0] grants_sum;
    logic        stall_c;

    assign grants_sum = {1'b0, perf_grants} + 33'(grant_cnt);
    assign stall_c    = |(fu_valid & ~ready_c);

    // Squash cycles are excluded; grant_cnt is already zero then but stalls are not
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_grants       <= '0;
            perf_stall_cycles <= '0;
        end else if (!squash) begin
            perf_grants <= grants_sum[32] ? '1 : grants_sum[31:0];
            if (stall_c && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: grant/slot tables plus reset, single-result and perf sequences.
module tb_cdb_arbiter;
    localparam int NUM_FU = 6;
    localparam int CDB_W  = 3;
    localparam int TAG_W  = 5;
    localparam int XLEN   = 32;
    localparam int PAY_W  = TAG_W + 2*XLEN + 2;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     squash = 1'b0;
    logic [NUM_FU-1:0]        fu_valid = '0;
    logic [NUM_FU*TAG_W-1:0]  fu_tag = '0;
    logic [NUM_FU*XLEN-1:0]   fu_value = '0;
    logic [NUM_FU-1:0]        fu_take_branch = '0;
    logic [NUM_FU*XLEN-1:0]   fu_npc = '0;
    logic [NUM_FU-1:0]        fu_halt = '0;
    logic [NUM_FU-1:0]        fu_ready;
    logic [CDB_W-1:0]         cdb_valid;
    logic [CDB_W*TAG_W-1:0]   cdb_tag;
    logic [CDB_W*XLEN-1:0]    cdb_value;
    logic [CDB_W-1:0]         cdb_take_branch;
    logic [CDB_W*XLEN-1:0]    cdb_npc;
    logic [CDB_W-1:0]         cdb_halt;
`ifdef CDB_ARB_PERF_EN
    logic [31:0]              perf_grants;
    logic [31:0]              perf_stall_cycles;
`endif

    cdb_arbiter #(.NUM_FU(NUM_FU), .CDB_W(CDB_W), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clock           (clock),
        .reset           (reset),
        .squash          (squash),
        .fu_valid        (fu_valid),
        .fu_tag          (fu_tag),
        .fu_value        (fu_value),
        .fu_take_branch  (fu_take_branch),
        .fu_npc          (fu_npc),
        .fu_halt         (fu_halt),
        .fu_ready        (fu_ready),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_value       (cdb_value),
        .cdb_take_branch (cdb_take_branch),
        .cdb_npc         (cdb_npc),
        .cdb_halt        (cdb_halt)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_grants       (perf_grants),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [NUM_FU-1:0] valid;
        logic              sq;
        logic [NUM_FU-1:0] exp_ready;
        int                s0, s1, s2;   // FU index expected in each slot, -1 = empty
    } vec_t;

    vec_t tbl[12];

    // Fixed per-FU payload: tag = FU index, distinct value/npc, odd FUs taken, FU2 halts
    function automatic logic [PAY_W-1:0] pay(input int i);
        logic [XLEN-1:0] v;
        logic [XLEN-1:0] n;
        v = 32'hC0DE_0000 | (32'(i) * 32'h111);
        n = 32'h0000_4000 + 32'(i) * 32'd4;
        return {TAG_W'(i), v, (i % 2) == 1, n, i == 2};
    endfunction

    function automatic logic [PAY_W-1:0] slot_act(input int k);
        return {cdb_tag[k*TAG_W +: TAG_W], cdb_value[k*XLEN +: XLEN], cdb_take_branch[k],
                cdb_npc[k*XLEN +: XLEN], cdb_halt[k]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_fus(input logic [NUM_FU-1:0] v);
        logic [PAY_W-1:0] p;
        fu_valid = v;
        for (int i = 0; i < NUM_FU; i++) begin
            p = pay(i);
            {fu_tag[i*TAG_W +: TAG_W], fu_value[i*XLEN +: XLEN], fu_take_branch[i],
             fu_npc[i*XLEN +: XLEN], fu_halt[i]} = p;
        end
    endtask

    // Inputs applied just after a rising edge; fu_ready sampled on the falling edge,
    // the registered CDB sampled just after the following rising edge.
    task automatic run_vec(input string tag, input vec_t v);
        int               s[3];
        logic [CDB_W-1:0] ev;
        drive_fus(v.valid);
        squash = v.sq;
        @(negedge clock);
        check({tag, " fu_ready"}, 128'(fu_ready), 128'(v.exp_ready));
        @(posedge clock);
        #1;
        squash   = 1'b0;
        fu_valid = '0;
        s[0] = v.s0; s[1] = v.s1; s[2] = v.s2;
        ev = '0;
        for (int k = 0; k < CDB_W; k++) ev[k] = (s[k] >= 0);
        check({tag, " cdb_valid"}, 128'(cdb_valid), 128'(ev));
        for (int k = 0; k < CDB_W; k++)
            check($sformatf("%s slot%0d", tag, k), 128'(slot_act(k)),
                  (s[k] >= 0) ? 128'(pay(s[k])) : 128'd0);
    endtask

    initial begin
        vec_t rv;

        tbl[0]  = '{6'b111111, 1'b0, 6'b000111,  0,  1,  2};
        tbl[1]  = '{6'b111111, 1'b0, 6'b111000,  3,  4,  5};
        tbl[2]  = '{6'b100001, 1'b0, 6'b100001,  0,  5, -1};
        tbl[3]  = '{6'b000000, 1'b0, 6'b000000, -1, -1, -1};
        tbl[4]  = '{6'b110000, 1'b0, 6'b110000,  4,  5, -1};
        tbl[5]  = '{6'b001000, 1'b0, 6'b001000,  3, -1, -1};
        tbl[6]  = '{6'b110010, 1'b0, 6'b110010,  4,  5,  1};
        tbl[7]  = '{6'b111111, 1'b0, 6'b011100,  2,  3,  4};
        tbl[8]  = '{6'b111111, 1'b1, 6'b000000, -1, -1, -1};
        tbl[9]  = '{6'b101011, 1'b0, 6'b100011,  5,  0,  1};
        tbl[10] = '{6'b101011, 1'b0, 6'b101001,  3,  5,  0};
        tbl[11] = '{6'b000001, 1'b0, 6'b000001,  0, -1, -1};

        // Reset held two cycles with every FU requesting
        reset = 1'b1;
        drive_fus(6'b111111);
        @(negedge clock);
        check("reset c1 fu_ready", 128'(fu_ready), 128'd0);
        @(negedge clock);
        check("reset c2 fu_ready", 128'(fu_ready), 128'd0);
        @(posedge clock);
        #1;
        reset    = 1'b0;
        fu_valid = '0;
        check("post-reset cdb_valid", 128'(cdb_valid), 128'd0);
        check("post-reset slot0", 128'(slot_act(0)), 128'd0);

        for (int n = 0; n < 12; n++) run_vec($sformatf("v%0d", n), tbl[n]);

        // Reset while CDB holds a result and all FUs request
        drive_fus(6'b111111);
        reset = 1'b1;
        @(negedge clock);
        check("midreset fu_ready", 128'(fu_ready), 128'd0);
        @(posedge clock);
        #1;
        reset    = 1'b0;
        fu_valid = '0;
        check("midreset cdb_valid", 128'(cdb_valid), 128'd0);
        check("midreset slot0", 128'(slot_act(0)), 128'd0);

        // rr_ptr back at 0: FU0 must precede FU5 in slot order
        rv = '{6'b100001, 1'b0, 6'b100001, 0, 5, -1};
        run_vec("ptr-after-reset", rv);

        // Single result, tag 5 / value 0xDEAD
        drive_fus(6'b000001);
        fu_tag[TAG_W-1:0] = 5'd5;
        fu_value[XLEN-1:0] = 32'hDEAD;
        @(negedge clock);
        check("single fu_ready", 128'(fu_ready), 128'(6'b000001));
        @(posedge clock);
        #1;
        fu_valid = '0;
        check("single cdb_valid", 128'(cdb_valid), 128'(3'b001));
        check("single tag", 128'(cdb_tag[TAG_W-1:0]), 128'd5);
        check("single value", 128'(cdb_value[XLEN-1:0]), 128'h0000DEAD);

`ifdef CDB_ARB_PERF_EN
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("perf reset grants", 128'(perf_grants), 128'd0);
        drive_fus(6'b001111);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("perf grants", 128'(perf_grants), 128'd6);
        check("perf stalls", 128'(perf_stall_cycles), 128'd2);
        squash = 1'b1;
        @(posedge clock);
        #1;
        squash   = 1'b0;
        fu_valid = '0;
        check("perf squash grants", 128'(perf_grants), 128'd6);
        check("perf squash stalls", 128'(perf_stall_cycles), 128'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the 3-wide common data bus among NUM_FU functional-unit completion ports.
- Each cycle it grants up to CDB_W ready results using rotating priority and registers them onto the CDB.
- The CDB feeds the ROB complete port (value, tag, take_branch, NPC, halt) and RS wakeup.
- Losers are back-pressured through fu_ready; results are never dropped except on squash.

Parameters:
- NUM_FU, 6, number of completing requesters.
- CDB_W, 3, CDB slots per cycle; must be <= NUM_FU.
- TAG_W, 5, ROB tag width (clog2 of ROBLEN=32).
- XLEN, 32, data/NPC width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- squash  in  1  branch-mispredict flush.
- fu_valid  in  NUM_FU  result pending per FU.
- fu_tag  in  NUM_FU*TAG_W  destination ROB tag, FU i at bits [i*TAG_W +: TAG_W].
- fu_value  in  NUM_FU*XLEN  result value.
- fu_take_branch  in  NUM_FU  resolved branch taken.
- fu_npc  in  NUM_FU*XLEN  resolved next PC.
- fu_halt  in  NUM_FU  halt instruction completed.
- fu_ready  out  NUM_FU  grant; transfer when fu_valid[i] && fu_ready[i].
- cdb_valid  out  CDB_W  slot valid.
- cdb_tag  out  CDB_W*TAG_W  slot tag.
- cdb_value  out  CDB_W*XLEN  slot value.
- cdb_take_branch  out  CDB_W  slot branch taken.
- cdb_npc  out  CDB_W*XLEN  slot NPC.
- cdb_halt  out  CDB_W  slot halt.

Behaviour:
- State: rr_ptr (clog2(NUM_FU) bits) plus registered CDB slot bank.
- Reset: rr_ptr=0; all cdb_* outputs 0; fu_ready=0 during reset.
- Grant (combinational):
  - Scan FUs in order rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - The first min(CDB_W, #valid) FUs with fu_valid=1 get fu_ready=1; all others get 0.
  - fu_ready[i] never asserts while fu_valid[i]=0.
- Producer rule: an FU holds fu_valid and its payload stable until granted. The arbiter does not check this.
- Latency: a result granted in cycle N appears on the CDB in cycle N+1, registered.
- Slot packing: the k-th grant in scan order goes to slot k. Slots are filled contiguously from 0; unused slots have valid=0 and all payload fields 0. ROB stops at the first invalid slot, so gaps are illegal.
- Pointer update:
  - If any grant: rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
  - If no grant: rr_ptr holds.
  - Wrap-around is modulo NUM_FU, not a power of two.
- Fairness: a continuously valid FU is granted within ceil(NUM_FU/CDB_W) cycles; 2 cycles at defaults.
- Squash:
  - Same cycle: fu_ready=0 for all FUs, no grants, rr_ptr holds.
  - Next cycle: cdb_valid=0 and payload 0.
  - FUs are flushed externally. Results pending at squash are not broadcast.
- Reset or squash mid-stream: registered slots are discarded; no partial broadcast.
- Duplicate tags in one cycle are not detected; each is forwarded in scan order.
- No internal buffering beyond the one output register stage; throughput is CDB_W results/cycle.

Optional Feature:
- Macro CDB_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_grants (32 bits): total granted results.
  - Adds perf_stall_cycles (32 bits): cycles where at least one fu_valid was denied.
  - Both reset to 0 and saturate at all-ones.
  - Neither counter increments during reset or squash cycles.
- Undefined: both ports and counters are absent; grant behaviour is identical.

Test Plan:
- Reset held 2 cycles with all fu_valid=1 -> fu_ready=0; after reset: cdb_valid=000, rr_ptr=0.
- Single result: fu_valid=000001, tag 5, value 0xDEAD -> fu_ready[0]=1 same cycle; next cycle slot0 valid, tag 5, value 0xDEAD; cdb_valid=001.
- All 6 FUs valid and held (FU i tag=i):
  - Cycle 0: grants FU0-2; next cycle tags {0,1,2}.
  - Cycle 1: grants FU3-5; next cycle tags {3,4,5}.
  - rr_ptr returns to 0.
- Wrap-around: rr_ptr=4, valid FUs {1,4,5} -> slot order tags {4,5,1}; rr_ptr becomes 2.
- Squash with fu_valid=111111 -> fu_ready=000000 that cycle; next cycle cdb_valid=000; rr_ptr unchanged.
- CDB_ARB_PERF_EN: 4 FUs held valid for 2 cycles.
  - Cycle 1: 3 granted, 1 stalled. Cycle 2: stalled FU and the next 2 granted.
  - Result: perf_grants=6, perf_stall_cycles=2.
